// File: rtl/ring_pkg.sv
// Shared constants for the cardinal ring: packet geometry, packet field
// positions and the NIC processor register map.
package ring_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int VC_BIT     = 31;

    localparam int DIR_BIT = 30;
    localparam int HOP_MSB = 25;
    localparam int HOP_LSB = 18;

    localparam logic [1:0] ADDR_IN_DATA  = 2'b00;
    localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
    localparam logic [1:0] ADDR_OUT_DATA = 2'b10;
    localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

endpackage : ring_pkg

// File: rtl/nic_chan_buf.sv
// Single-entry packet buffer with a full flag. A write lands only into an
// empty buffer; clear empties it but leaves the data in place.
module nic_chan_buf #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  clr_i,
    output logic                  full_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic                  full_q, full_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        // Writes into a full buffer are dropped, so write and clear never race.
        if (wr_en_i && !full_q) begin
            full_d = 1'b1;
            data_d = data_i;
        end else if (clr_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;

endmodule : nic_chan_buf

// File: rtl/ring_pe_nic.sv
// Processor-side NIC for the ring router PE port: one output and one input
// packet buffer, exposed to the processor through a 2-bit register map.
module ring_pe_nic #(
    parameter int DATA_WIDTH = ring_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = 2,
    parameter int VC_BIT     = ring_pkg::VC_BIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    input  logic                  net_polarity,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [DATA_WIDTH-1:0] net_do,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [DATA_WIDTH-1:0] net_di
);
    import ring_pkg::*;

    logic                  rd_en, wr_out, in_drain;
    logic                  out_full, in_full;
    logic [DATA_WIDTH-1:0] out_buf, in_buf;
    logic [DATA_WIDTH-1:0] d_out_q, d_out_d;

    assign rd_en    = nicEn & ~nicWrEn;
    assign wr_out   = nicEn & nicWrEn & (addr == ADDR_OUT_DATA);
    assign in_drain = rd_en & (addr == ADDR_IN_DATA) & in_full;

    nic_chan_buf #(.DATA_WIDTH(DATA_WIDTH)) u_out_buf (
        .clk     (clk),
        .rst_n   (reset),
        .wr_en_i (wr_out),
        .data_i  (d_in),
        .clr_i   (net_so),
        .full_o  (out_full),
        .data_o  (out_buf)
    );

    // net_si into a full buffer is a router protocol violation; the buffer drops it.
    nic_chan_buf #(.DATA_WIDTH(DATA_WIDTH)) u_in_buf (
        .clk     (clk),
        .rst_n   (reset),
        .wr_en_i (net_si),
        .data_i  (net_di),
        .clr_i   (in_drain),
        .full_o  (in_full),
        .data_o  (in_buf)
    );

    assign net_do = out_buf;
    assign net_so = out_full & net_ro & (net_polarity == out_buf[VC_BIT]);
    assign net_ri = ~in_full;

    always_comb begin
        d_out_d = d_out_q;
        if (rd_en) begin
            case (addr)
                ADDR_IN_DATA:  d_out_d = in_buf;
                ADDR_IN_STAT:  d_out_d = {{(DATA_WIDTH-1){1'b0}}, in_full};
                ADDR_OUT_STAT: d_out_d = {{(DATA_WIDTH-1){1'b0}}, out_full};
                default:       d_out_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_out_q <= '0;
        end else begin
            d_out_q <= d_out_d;
        end
    end

    assign d_out = d_out_q;

endmodule : ring_pe_nic

// File: tb/tb_ring_pe_nic.sv
// Directed bench for ring_pe_nic: register map, VC-gated send, input capture,
// overrun protection and same-edge concurrency.
module tb_ring_pe_nic;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic [63:0] d_in, d_out, net_do, net_di;
    logic        nicEn, nicWrEn, net_polarity, net_so, net_ro, net_si, net_ri;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    ring_pe_nic dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_polarity (net_polarity),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [63:0] data);
        nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = data;
        cyc();
        nicEn = 1'b0; nicWrEn = 1'b0;
        $display("write  addr=10 data=%h", data);
    endtask

    task automatic rd(input logic [1:0] a);
        nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
        cyc();
        nicEn = 1'b0;
        $display("read   addr=%b d_out=%h", a, d_out);
    endtask

    task automatic test_reset();
        reset = 1'b0; cyc(); cyc();
        reset = 1'b1; cyc();
        compared++;
        if (net_so !== 1'b0 || net_ri !== 1'b1 || d_out !== 64'd0 || net_do !== 64'd0) begin
            mismatched++;
            $display("FAIL reset_init so=%b ri=%b d_out=%h do=%h required so=0 ri=1 d_out=0 do=0",
                     net_so, net_ri, d_out, net_do);
        end
        // Fill both buffers and make d_out nonzero, then reset mid-cycle.
        net_ro = 1'b0;
        wr(64'h0000_0000_0000_0077);
        net_si = 1'b1; net_di = 64'hAAAA_BBBB_CCCC_DDDD;
        cyc();
        net_si = 1'b0;
        rd(2'b11);
        compared++;
        if (d_out !== 64'd1 || net_ri !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_prefill d_out=%h ri=%b required d_out=1 ri=0", d_out, net_ri);
        end
        #2 reset = 1'b0;
        #1;
        compared++;
        if (net_so !== 1'b0 || net_ri !== 1'b1 || d_out !== 64'd0 || net_do !== 64'd0) begin
            mismatched++;
            $display("FAIL reset_async so=%b ri=%b d_out=%h do=%h required 0/1/0/0",
                     net_so, net_ri, d_out, net_do);
        end
        cyc();
        reset = 1'b1;
        cyc();
        rd(2'b11);
        compared++;
        if (d_out !== 64'd0) begin
            mismatched++;
            $display("FAIL reset_out_stat d_out=%h required 0", d_out);
        end
        rd(2'b01);
        compared++;
        if (d_out !== 64'd0) begin
            mismatched++;
            $display("FAIL reset_in_stat d_out=%h required 0", d_out);
        end
        $display("reset  done");
    endtask

    task automatic test_vc_send();
        net_ro = 1'b1; net_polarity = 1'b0;
        wr(64'h0000_0000_8000_00AA);
        compared++;
        if (net_so !== 1'b0 || net_do !== 64'h0000_0000_8000_00AA) begin
            mismatched++;
            $display("FAIL vc1_even so=%b do=%h required so=0 do=00000000800000aa", net_so, net_do);
        end
        net_polarity = 1'b1; #1;
        compared++;
        if (net_so !== 1'b1) begin
            mismatched++;
            $display("FAIL vc1_odd so=%b required 1", net_so);
        end
        cyc();
        net_polarity = 1'b0; #1;
        compared++;
        if (net_so !== 1'b0) begin
            mismatched++;
            $display("FAIL vc1_after so=%b required 0", net_so);
        end
        rd(2'b11);
        compared++;
        if (d_out !== 64'd0) begin
            mismatched++;
            $display("FAIL vc1_stat d_out=%h required 0", d_out);
        end
        rd(2'b10);
        compared++;
        if (d_out !== 64'd0) begin
            mismatched++;
            $display("FAIL rd_addr10 d_out=%h required 0", d_out);
        end
    endtask

    task automatic test_hold();
        net_ro = 1'b0; net_polarity = 1'b0;
        wr(64'h0000_0000_0000_00AB);
        for (int i = 0; i < 5; i++) begin
            net_polarity = ~net_polarity; #1;
            compared++;
            if (net_so !== 1'b0) begin
                mismatched++;
                $display("FAIL hold_so cyc=%0d so=%b required 0", i, net_so);
            end
            cyc();
        end
        rd(2'b11);
        compared++;
        if (d_out !== 64'd1) begin
            mismatched++;
            $display("FAIL hold_stat d_out=%h required 1", d_out);
        end
        wr(64'h0000_0000_0000_DEAD);
        compared++;
        if (net_do !== 64'h0000_0000_0000_00AB) begin
            mismatched++;
            $display("FAIL hold_drop do=%h required 00000000000000ab", net_do);
        end
        net_ro = 1'b1; net_polarity = 1'b1; #1;
        compared++;
        if (net_so !== 1'b0) begin
            mismatched++;
            $display("FAIL hold_odd so=%b required 0", net_so);
        end
        net_polarity = 1'b0; #1;
        compared++;
        if (net_so !== 1'b1 || net_do !== 64'h0000_0000_0000_00AB) begin
            mismatched++;
            $display("FAIL hold_send so=%b do=%h required so=1 do=00000000000000ab", net_so, net_do);
        end
        cyc();
        net_ro = 1'b0;
        rd(2'b11);
        compared++;
        if (d_out !== 64'd0) begin
            mismatched++;
            $display("FAIL hold_stat2 d_out=%h required 0", d_out);
        end
    endtask

    task automatic test_receive();
        net_si = 1'b1; net_di = 64'h1234_5678_9ABC_DEF0; #1;
        compared++;
        if (net_ri !== 1'b1) begin
            mismatched++;
            $display("FAIL rx_ready ri=%b required 1", net_ri);
        end
        cyc();
        net_si = 1'b0; net_di = '0;
        compared++;
        if (net_ri !== 1'b0) begin
            mismatched++;
            $display("FAIL rx_full ri=%b required 0", net_ri);
        end
        rd(2'b01);
        compared++;
        if (d_out !== 64'd1) begin
            mismatched++;
            $display("FAIL rx_stat d_out=%h required 1", d_out);
        end
        rd(2'b00);
        compared++;
        if (d_out !== 64'h1234_5678_9ABC_DEF0 || net_ri !== 1'b1) begin
            mismatched++;
            $display("FAIL rx_data d_out=%h ri=%b required 123456789abcdef0 ri=1", d_out, net_ri);
        end
        rd(2'b00);
        compared++;
        if (d_out !== 64'h1234_5678_9ABC_DEF0 || net_ri !== 1'b1) begin
            mismatched++;
            $display("FAIL rx_stale d_out=%h ri=%b required 123456789abcdef0 ri=1", d_out, net_ri);
        end
    endtask

    task automatic test_overrun();
        net_si = 1'b1; net_di = 64'h0000_0000_0000_A5A5;
        cyc();
        net_di = 64'h0000_0000_0000_5555;
        cyc();
        cyc();
        net_si = 1'b0;
        rd(2'b00);
        compared++;
        if (d_out !== 64'h0000_0000_0000_A5A5) begin
            mismatched++;
            $display("FAIL overrun d_out=%h required 000000000000a5a5", d_out);
        end
        compared++;
        if (net_ri !== 1'b1) begin
            mismatched++;
            $display("FAIL overrun_ri ri=%b required 1", net_ri);
        end
    endtask

    task automatic test_simultaneous();
        net_ro = 1'b0; net_polarity = 1'b0;
        wr(64'h0000_0000_8000_0011);
        net_ro = 1'b1; net_polarity = 1'b1;
        net_si = 1'b1; net_di = 64'h0000_0000_0000_CAFE;
        nicEn = 1'b1; nicWrEn = 1'b0; addr = 2'b11; #1;
        compared++;
        if (net_so !== 1'b1) begin
            mismatched++;
            $display("FAIL sim_pre so=%b required 1", net_so);
        end
        cyc();
        nicEn = 1'b0; net_si = 1'b0; net_ro = 1'b0;
        $display("simul  send+recv+read d_out=%h", d_out);
        compared++;
        if (d_out !== 64'd1 || net_so !== 1'b0 || net_ri !== 1'b0) begin
            mismatched++;
            $display("FAIL sim_edge d_out=%h so=%b ri=%b required d_out=1 so=0 ri=0",
                     d_out, net_so, net_ri);
        end
        rd(2'b11);
        compared++;
        if (d_out !== 64'd0) begin
            mismatched++;
            $display("FAIL sim_out_stat d_out=%h required 0", d_out);
        end
        rd(2'b00);
        compared++;
        if (d_out !== 64'h0000_0000_0000_CAFE) begin
            mismatched++;
            $display("FAIL sim_rx d_out=%h required 000000000000cafe", d_out);
        end
    endtask

    initial begin
        reset = 1'b1; addr = '0; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
        net_polarity = 1'b0; net_ro = 1'b0; net_si = 1'b0; net_di = '0;
        #1;
        test_reset();
        test_vc_send();
        test_hold();
        test_receive();
        test_overrun();
        test_simultaneous();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_ring_pe_nic
